// File: rtl/bcd_calc_control.sv
// bcd_calc_control: keypad sequencer for a 4-digit BCD calculator.
// Collects operands and operator, latches ALU results, and drives the display.
module bcd_calc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [1:0]  op_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    output logic [15:0] disp,
    output logic        disp_neg,
    output logic        disp_err,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {ENTER_A = 2'b00, ENTER_B = 2'b01, SHOW_RES = 2'b10} st_t;
    st_t         st;
    logic [2:0]  cnt;
    logic        is_digit, is_op, can_chain;
    logic [1:0]  key_op;
    logic [15:0] shift_a, shift_b, fresh_a;
    assign state   = st;
    assign is_digit = key_code <= 4'h9;
    assign is_op    = key_code >= 4'hA && key_code <= 4'hC;
    // 0xA/0xB/0xC map onto op_sel 00/01/10
    assign key_op   = key_code[1:0] + 2'd2;
    assign shift_a  = {op_a[11:0], key_code};
    assign shift_b  = {op_b[11:0], key_code};
    assign fresh_a  = {12'h000, key_code};
    // A result can seed the next operation only when it is a valid non-negative value
    assign can_chain = st == ENTER_A || (st == SHOW_RES && !disp_neg && !disp_err);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ENTER_A;
            cnt      <= 3'd0;
            op_a     <= 16'h0000;
            op_b     <= 16'h0000;
            op_sel   <= 2'b00;
            disp     <= 16'h0000;
            disp_neg <= 1'b0;
            disp_err <= 1'b0;
        end else if (key_valid) begin
            if (key_code == 4'hF) begin
                st       <= ENTER_A;
                cnt      <= 3'd0;
                op_a     <= 16'h0000;
                op_b     <= 16'h0000;
                op_sel   <= 2'b00;
                disp     <= 16'h0000;
                disp_neg <= 1'b0;
                disp_err <= 1'b0;
            end else if (is_digit) begin
                case (st)
                    ENTER_A: if (cnt < 3'd4) begin
                        op_a <= shift_a;
                        disp <= shift_a;
                        cnt  <= cnt + 3'd1;
                    end
                    ENTER_B: if (cnt < 3'd4) begin
                        op_b <= shift_b;
                        disp <= shift_b;
                        cnt  <= cnt + 3'd1;
                    end
                    default: begin
                        op_a     <= fresh_a;
                        disp     <= fresh_a;
                        op_b     <= 16'h0000;
                        cnt      <= 3'd1;
                        disp_neg <= 1'b0;
                        disp_err <= 1'b0;
                        st       <= ENTER_A;
                    end
                endcase
            end else if (is_op) begin
                if (can_chain) begin
                    if (st == SHOW_RES)
                        op_a <= disp;
                    op_sel <= key_op;
                    op_b   <= 16'h0000;
                    disp   <= 16'h0000;
                    cnt    <= 3'd0;
                    st     <= ENTER_B;
                end else if (st == ENTER_B && cnt == 3'd0) begin
                    op_sel <= key_op;
                end
            end else if (key_code == 4'hE && st == ENTER_B) begin
                disp     <= alu_result;
                disp_neg <= op_sel == 2'b01 && alu_neg;
                disp_err <= (op_sel == 2'b00 || op_sel == 2'b10) && alu_ovf;
                st       <= SHOW_RES;
            end
        end
    end
endmodule

// File: tb/tb_bcd_calc_control.sv
// tb_bcd_calc_control: scoreboard bench; each key pushes its expected outputs,
// which are popped and compared one cycle later.
module tb_bcd_calc_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] op_a, op_b, alu_result = 16'h0000, disp;
    logic [1:0]  op_sel, state;
    logic        alu_neg = 1'b0, alu_ovf = 1'b0, disp_neg, disp_err;
    int          errors = 0, checks = 0;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] a, b;
        logic [1:0]  sel;
        logic [15:0] d;
        logic        n, e;
    } exp_t;
    exp_t q[$];

    bcd_calc_control dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_result(alu_result),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf), .disp(disp), .disp_neg(disp_neg),
        .disp_err(disp_err), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [1:0] st, logic [15:0] a, logic [15:0] b,
                                logic [1:0] sel, logic [15:0] d, logic n, logic e);
        mk = '{st: st, a: a, b: b, sel: sel, d: d, n: n, e: e};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".state"}, 16'(state), 16'(e.st));
        chk({tag, ".op_a"}, op_a, e.a);
        chk({tag, ".op_b"}, op_b, e.b);
        chk({tag, ".op_sel"}, 16'(op_sel), 16'(e.sel));
        chk({tag, ".disp"}, disp, e.d);
        chk({tag, ".neg"}, 16'(disp_neg), 16'(e.n));
        chk({tag, ".err"}, 16'(disp_err), 16'(e.e));
    endtask

    // Key is driven at a negedge; consecutive calls keep key_valid high back to back.
    task automatic press(input string tag, input logic [3:0] k, input exp_t e);
        key_valid = 1'b1;
        key_code  = k;
        q.push_back(e);
        @(negedge clk);
        key_valid = 1'b0;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else
            check_all(tag, q.pop_front());
    endtask

    task automatic idle(input string tag, input exp_t e);
        q.push_back(e);
        @(negedge clk);
        check_all(tag, q.pop_front());
    endtask

    localparam logic [1:0] A = 2'b00, B = 2'b01, S = 2'b10;
    exp_t z;

    initial begin
        z = mk(A, 16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0);
        #1 check_all("reset", z);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // five digits, fifth dropped; 0xD and idle cycles change nothing
        press("d1", 4'h1, mk(A, 16'h0001, 16'h0, 2'b00, 16'h0001, 1'b0, 1'b0));
        press("d2", 4'h2, mk(A, 16'h0012, 16'h0, 2'b00, 16'h0012, 1'b0, 1'b0));
        press("d3", 4'h3, mk(A, 16'h0123, 16'h0, 2'b00, 16'h0123, 1'b0, 1'b0));
        press("d4", 4'h4, mk(A, 16'h1234, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0));
        press("d5", 4'h5, mk(A, 16'h1234, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0));
        press("keyD", 4'hD, mk(A, 16'h1234, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0));
        press("eqA", 4'hE, mk(A, 16'h1234, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0));
        idle("idle", mk(A, 16'h1234, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0));
        press("clr1", 4'hF, z);
        // 12 + 34 = 46
        press("add1", 4'h1, mk(A, 16'h0001, 16'h0, 2'b00, 16'h0001, 1'b0, 1'b0));
        press("add2", 4'h2, mk(A, 16'h0012, 16'h0, 2'b00, 16'h0012, 1'b0, 1'b0));
        press("addop", 4'hA, mk(B, 16'h0012, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0));
        press("add3", 4'h3, mk(B, 16'h0012, 16'h0003, 2'b00, 16'h0003, 1'b0, 1'b0));
        press("add4", 4'h4, mk(B, 16'h0012, 16'h0034, 2'b00, 16'h0034, 1'b0, 1'b0));
        alu_result = 16'h0046; alu_neg = 1'b1; alu_ovf = 1'b0;
        press("addeq", 4'hE, mk(S, 16'h0012, 16'h0034, 2'b00, 16'h0046, 1'b0, 1'b0));
        // chain multiply from result, overflow
        press("mulop", 4'hC, mk(B, 16'h0046, 16'h0, 2'b10, 16'h0000, 1'b0, 1'b0));
        press("mul9a", 4'h9, mk(B, 16'h0046, 16'h0009, 2'b10, 16'h0009, 1'b0, 1'b0));
        press("mul9b", 4'h9, mk(B, 16'h0046, 16'h0099, 2'b10, 16'h0099, 1'b0, 1'b0));
        press("mul9c", 4'h9, mk(B, 16'h0046, 16'h0999, 2'b10, 16'h0999, 1'b0, 1'b0));
        press("mul9d", 4'h9, mk(B, 16'h0046, 16'h9999, 2'b10, 16'h9999, 1'b0, 1'b0));
        press("mul9e", 4'h9, mk(B, 16'h0046, 16'h9999, 2'b10, 16'h9999, 1'b0, 1'b0));
        alu_result = 16'hFFFF; alu_neg = 1'b1; alu_ovf = 1'b1;
        press("muleq", 4'hE, mk(S, 16'h0046, 16'h9999, 2'b10, 16'hFFFF, 1'b0, 1'b1));
        press("errop", 4'hA, mk(S, 16'h0046, 16'h9999, 2'b10, 16'hFFFF, 1'b0, 1'b1));
        press("eqS", 4'hE, mk(S, 16'h0046, 16'h9999, 2'b10, 16'hFFFF, 1'b0, 1'b1));
        press("clr2", 4'hF, z);
        // 5 - 9 negative; overflow flag must not leak into a subtract
        press("sub5", 4'h5, mk(A, 16'h0005, 16'h0, 2'b00, 16'h0005, 1'b0, 1'b0));
        press("subop", 4'hB, mk(B, 16'h0005, 16'h0, 2'b01, 16'h0000, 1'b0, 1'b0));
        press("sub9", 4'h9, mk(B, 16'h0005, 16'h0009, 2'b01, 16'h0009, 1'b0, 1'b0));
        alu_result = 16'h0004; alu_neg = 1'b1; alu_ovf = 1'b1;
        press("subeq", 4'hE, mk(S, 16'h0005, 16'h0009, 2'b01, 16'h0004, 1'b1, 1'b0));
        press("negop", 4'hA, mk(S, 16'h0005, 16'h0009, 2'b01, 16'h0004, 1'b1, 1'b0));
        press("neg7", 4'h7, mk(A, 16'h0007, 16'h0, 2'b01, 16'h0007, 1'b0, 1'b0));
        press("clr3", 4'hF, z);
        // operator replacement only before any B digit
        press("rep1", 4'h1, mk(A, 16'h0001, 16'h0, 2'b00, 16'h0001, 1'b0, 1'b0));
        press("repadd", 4'hA, mk(B, 16'h0001, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0));
        press("repsub", 4'hB, mk(B, 16'h0001, 16'h0, 2'b01, 16'h0000, 1'b0, 1'b0));
        press("rep2", 4'h2, mk(B, 16'h0001, 16'h0002, 2'b01, 16'h0002, 1'b0, 1'b0));
        press("repmul", 4'hC, mk(B, 16'h0001, 16'h0002, 2'b01, 16'h0002, 1'b0, 1'b0));
        press("clr4", 4'hF, z);
        // asynchronous reset mid-entry
        press("ar1", 4'h1, mk(A, 16'h0001, 16'h0, 2'b00, 16'h0001, 1'b0, 1'b0));
        press("arop", 4'hA, mk(B, 16'h0001, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0));
        press("arb1", 4'h1, mk(B, 16'h0001, 16'h0001, 2'b00, 16'h0001, 1'b0, 1'b0));
        press("arb2", 4'h2, mk(B, 16'h0001, 16'h0012, 2'b00, 16'h0012, 1'b0, 1'b0));
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", z);
        @(negedge clk);
        rst_n = 1'b1;
        press("post3", 4'h3, mk(A, 16'h0003, 16'h0, 2'b00, 16'h0003, 1'b0, 1'b0));
        chk("sb_empty", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_calc_control.md
BCD_CALC_CONTROL -- requirements
Module: bcd_calc_control

Interface
REQ-001 The block SHALL have the ports below, one clock domain; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0x0-0x9 digit; 0xA add; 0xB sub; 0xC mul; 0xD ignored; 0xE equals; 0xF clear
- op_a  out  16  operand A to ALU, 4 BCD digits
- op_b  out  16  operand B to ALU, 4 BCD digits
- op_sel  out  2  00 add, 01 sub, 10 mul, 11 unused
- alu_result  in  16  ALU BCD result for current op_a/op_b/op_sel
- alu_neg  in  1  ALU subtract result negative
- alu_ovf  in  1  ALU add/mul overflow
- disp  out  16  BCD value for display
- disp_neg  out  1  displayed value negative
- disp_err  out  1  displayed value is overflow
- state  out  2  00 ENTER_A, 01 ENTER_B, 10 SHOW_RES

Function
REQ-002 The block SHALL implement FSM states ENTER_A, ENTER_B and SHOW_RES; all outputs are registered.
REQ-003 The block SHALL keep a 3-bit digit counter for the operand being entered, range 0-4.
REQ-004 Digit key, ENTER_A: if count<4, op_a <= {op_a[11:0], key_code} and count+1; if count=4, the key SHALL be ignored.
REQ-005 Digit key, ENTER_B: same as REQ-004 applied to op_b.
REQ-006 Digit key, SHOW_RES: op_a <= {12'h000, key_code}, count <= 1, op_b <= 0, disp_neg/disp_err <= 0, go to ENTER_A.
REQ-007 Operator key (0xA-0xC), ENTER_A: op_sel latched, op_b <= 0, count <= 0, go to ENTER_B.
REQ-008 Operator key, ENTER_B with count=0: op_sel replaced; with count>0: ignored.
REQ-009 Operator key, SHOW_RES with disp_neg=0 and disp_err=0: op_a <= disp, op_sel latched, op_b <= 0, count <= 0, go to ENTER_B. With either flag set, the key SHALL be ignored.
REQ-010 Equals key, ENTER_B: on that edge, disp <= alu_result, disp_neg <= alu_neg when op_sel=01 (else 0), disp_err <= alu_ovf when op_sel is 00 or 10 (else 0); go to SHOW_RES.
REQ-011 Equals key in ENTER_A or SHOW_RES SHALL be ignored.
REQ-012 Clear key (0xF) in any state SHALL force the reset values of REQ-016 on the next edge.
REQ-013 Key 0xD and any cycle with key_valid=0 SHALL leave all state unchanged.
REQ-014 disp SHALL equal op_a in ENTER_A and op_b in ENTER_B, updated on the same edge as the operand. It SHALL hold the latched result in SHOW_RES.
REQ-015 Keys SHALL take effect one cycle after the key_valid edge. Back-to-back key_valid pulses SHALL each be processed in order, with no dead cycle.

Reset
REQ-016 While rst_n=0: state=ENTER_A, op_a=op_b=disp=0x0000, op_sel=00, count=0, disp_neg=disp_err=0, asynchronously. Reset mid-entry SHALL discard all partial operands.
REQ-017 The first rising clk edge after rst_n deasserts SHALL be able to process a key.

Verification
REQ-018 Keys 1,2,3,4,5 -> op_a=0x1234 (fifth digit ignored), state=ENTER_A, disp=0x1234.
REQ-019 Keys 1,2,+,3,4,= with alu_result=0x0046 -> SHOW_RES, disp=0x0046, disp_neg=0, disp_err=0.
REQ-020 Keys 5,-,9,= with alu_result=0x0004, alu_neg=1 -> disp=0x0004, disp_neg=1. A following + SHALL be ignored; a following digit 7 -> ENTER_A, op_a=0x0007.
REQ-021 Result 0x0046, then * -> op_a=0x0046, op_sel=10, state=ENTER_B. Then 9,9,9,9,= with alu_ovf=1 and alu_result=0xFFFF -> disp=0xFFFF, disp_err=1.
REQ-022 Keys 1,+,- -> op_sel=01, state ENTER_B. Then 2,* -> op_sel stays 01. Clear -> all outputs at REQ-016 values.
REQ-023 rst_n pulsed low mid-cycle during ENTER_B with op_b=0x0012 -> outputs reset immediately without waiting for clk; next key 3 -> op_a=0x0003.
